// File: rtl/axis_insert_scheduler.sv
// -----------------------------------------------------------------------------
// axis_insert_scheduler
//
// Shares one header-insert datapath between NUM_CH requesters. Each requester
// has a header stream and a data stream. One channel is granted per packet.
// The grant is held until the inserter's output emits its tlast, so packets
// from different channels never interleave. Exactly one header is forwarded
// per packet. The block does no buffering: it is a registered FSM plus a
// combinational mux.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   ch_hdr_*            per-channel header streams (valid/data/keep/ready)
//   ch_dat_*            per-channel data streams (valid/data/keep/last/ready)
//   ins_hdr_*           muxed header stream to the inserter (s00)
//   ins_dat_*           muxed data stream to the inserter (s01)
//   ins_out_*           monitor taps of the inserter output handshake
//   grant               one-hot current owner, 0 when idle
//   busy                high whenever the FSM is not idle
//   pkt_cnt             completed packets, wraps
// -----------------------------------------------------------------------------
module axis_insert_scheduler #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int NUM_CH       = 4,
  parameter int CNT_WD       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_hdr_tvalid,
  input  logic [NUM_CH*DATA_WD-1:0]      ch_hdr_tdata,
  input  logic [NUM_CH*DATA_BYTE_WD-1:0] ch_hdr_tkeep,
  output logic [NUM_CH-1:0]              ch_hdr_tready,
  input  logic [NUM_CH-1:0]              ch_dat_tvalid,
  input  logic [NUM_CH*DATA_WD-1:0]      ch_dat_tdata,
  input  logic [NUM_CH*DATA_BYTE_WD-1:0] ch_dat_tkeep,
  input  logic [NUM_CH-1:0]              ch_dat_tlast,
  output logic [NUM_CH-1:0]              ch_dat_tready,
  output logic                           ins_hdr_tvalid,
  output logic [DATA_WD-1:0]             ins_hdr_tdata,
  output logic [DATA_BYTE_WD-1:0]        ins_hdr_tkeep,
  input  logic                           ins_hdr_tready,
  output logic                           ins_dat_tvalid,
  output logic [DATA_WD-1:0]             ins_dat_tdata,
  output logic [DATA_BYTE_WD-1:0]        ins_dat_tkeep,
  output logic                           ins_dat_tlast,
  input  logic                           ins_dat_tready,
  input  logic                           ins_out_tvalid,
  input  logic                           ins_out_tready,
  input  logic                           ins_out_tlast,
  output logic [NUM_CH-1:0]              grant,
  output logic                           busy,
  output logic [CNT_WD-1:0]              pkt_cnt
);

  localparam int IDX_WD = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t              r_state,    w_state_nxt;
  logic [NUM_CH-1:0]   r_grant,    w_grant_nxt;
  logic [IDX_WD-1:0]   r_gidx,     w_gidx_nxt;
  logic [IDX_WD-1:0]   r_ptr,      w_ptr_nxt;
  logic                r_hdr_done, w_hdr_done_nxt;
  logic                r_dat_done, w_dat_done_nxt;
  logic [CNT_WD-1:0]   r_pkt_cnt,  w_pkt_cnt_nxt;

  logic [NUM_CH-1:0]   w_req;
  logic                w_pick_vld;
  logic [IDX_WD-1:0]   w_pick_idx;
  logic                w_active;
  logic                w_hdr_hs;
  logic                w_dat_last_hs;
  logic                w_out_last_hs;
  logic                w_complete;

  // A channel only competes once both its header and its data are presented.
  assign w_req = ch_hdr_tvalid & ch_dat_tvalid;

  // Round-robin pick: first requester at or after r_ptr, wrapping around.
  always_comb begin
    logic [IDX_WD:0] cand;
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    cand       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, r_ptr} + (IDX_WD+1)'(k);
      if (cand >= (IDX_WD+1)'(NUM_CH))
        cand = cand - (IDX_WD+1)'(NUM_CH);
      if (!w_pick_vld && w_req[cand[IDX_WD-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = cand[IDX_WD-1:0];
      end
    end
  end

  // Datapath mux. Everything toward the inserter is held at 0 outside ACTIVE
  // so DRAIN and IDLE never move a beat.
  assign w_active = (r_state == S_ACTIVE);

  assign ins_hdr_tvalid = w_active & ch_hdr_tvalid[r_gidx] & ~r_hdr_done;
  assign ins_hdr_tdata  = w_active ? ch_hdr_tdata[r_gidx*DATA_WD +: DATA_WD] : '0;
  assign ins_hdr_tkeep  = w_active ? ch_hdr_tkeep[r_gidx*DATA_BYTE_WD +: DATA_BYTE_WD] : '0;

  assign ins_dat_tvalid = w_active & ch_dat_tvalid[r_gidx] & ~r_dat_done;
  assign ins_dat_tdata  = w_active ? ch_dat_tdata[r_gidx*DATA_WD +: DATA_WD] : '0;
  assign ins_dat_tkeep  = w_active ? ch_dat_tkeep[r_gidx*DATA_BYTE_WD +: DATA_BYTE_WD] : '0;
  assign ins_dat_tlast  = w_active & ch_dat_tlast[r_gidx];

  // Ready is returned only to the owner; r_grant is one-hot or zero.
  assign ch_hdr_tready = r_grant & {NUM_CH{w_active & ins_hdr_tready & ~r_hdr_done}};
  assign ch_dat_tready = r_grant & {NUM_CH{w_active & ins_dat_tready & ~r_dat_done}};

  assign w_hdr_hs      = ins_hdr_tvalid & ins_hdr_tready;
  assign w_dat_last_hs = ins_dat_tvalid & ins_dat_tready & ins_dat_tlast;
  assign w_out_last_hs = ins_out_tvalid & ins_out_tready & ins_out_tlast;

  assign grant   = r_grant;
  assign busy    = (r_state != S_IDLE);
  assign pkt_cnt = r_pkt_cnt;

  // Next-state logic
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_gidx_nxt     = r_gidx;
    w_ptr_nxt      = r_ptr;
    w_hdr_done_nxt = r_hdr_done;
    w_dat_done_nxt = r_dat_done;
    w_pkt_cnt_nxt  = r_pkt_cnt;
    w_complete     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_hdr_done_nxt = 1'b0;
        w_dat_done_nxt = 1'b0;
        if (w_pick_vld) begin
          w_grant_nxt = NUM_CH'(1) << w_pick_idx;
          w_gidx_nxt  = w_pick_idx;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_hdr_hs)      w_hdr_done_nxt = 1'b1;
        if (w_dat_last_hs) w_dat_done_nxt = 1'b1;
        // An out-tlast seen before the input tlast is a protocol violation
        // and is ignored; only count it once the input side is finished.
        if (w_dat_last_hs || r_dat_done) begin
          if (w_out_last_hs) w_complete  = 1'b1;
          else               w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Inserter may still owe a tail beat; hold the grant until it leaves.
        if (w_out_last_hs) w_complete = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_complete) begin
      w_state_nxt   = S_IDLE;
      w_grant_nxt   = '0;
      w_pkt_cnt_nxt = r_pkt_cnt + 1'b1;
      w_ptr_nxt     = (r_gidx == IDX_WD'(NUM_CH-1)) ? '0 : r_gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_gidx     <= '0;
      r_ptr      <= '0;
      r_hdr_done <= 1'b0;
      r_dat_done <= 1'b0;
      r_pkt_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_gidx     <= w_gidx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hdr_done <= w_hdr_done_nxt;
      r_dat_done <= w_dat_done_nxt;
      r_pkt_cnt  <= w_pkt_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_axis_insert_scheduler.sv
// -----------------------------------------------------------------------------
// Directed bench for axis_insert_scheduler (NUM_CH=4, DATA_WD=32). The bench
// plays both the requesters and the inserter; inputs change 1 time unit after
// the rising edge and outputs are checked 1 unit later.
// -----------------------------------------------------------------------------
module tb_axis_insert_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int KW  = 4;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_hdr_tvalid;
  logic [NCH*DW-1:0] ch_hdr_tdata;
  logic [NCH*KW-1:0] ch_hdr_tkeep;
  logic [NCH-1:0]    ch_hdr_tready;
  logic [NCH-1:0]    ch_dat_tvalid;
  logic [NCH*DW-1:0] ch_dat_tdata;
  logic [NCH*KW-1:0] ch_dat_tkeep;
  logic [NCH-1:0]    ch_dat_tlast;
  logic [NCH-1:0]    ch_dat_tready;
  logic              ins_hdr_tvalid;
  logic [DW-1:0]     ins_hdr_tdata;
  logic [KW-1:0]     ins_hdr_tkeep;
  logic              ins_hdr_tready;
  logic              ins_dat_tvalid;
  logic [DW-1:0]     ins_dat_tdata;
  logic [KW-1:0]     ins_dat_tkeep;
  logic              ins_dat_tlast;
  logic              ins_dat_tready;
  logic              ins_out_tvalid;
  logic              ins_out_tready;
  logic              ins_out_tlast;
  logic [NCH-1:0]    grant;
  logic              busy;
  logic [CW-1:0]     pkt_cnt;

  axis_insert_scheduler #(.DATA_WD(DW), .DATA_BYTE_WD(KW), .NUM_CH(NCH), .CNT_WD(CW)) dut (
    .clk(clk), .rst(rst),
    .ch_hdr_tvalid(ch_hdr_tvalid), .ch_hdr_tdata(ch_hdr_tdata),
    .ch_hdr_tkeep(ch_hdr_tkeep), .ch_hdr_tready(ch_hdr_tready),
    .ch_dat_tvalid(ch_dat_tvalid), .ch_dat_tdata(ch_dat_tdata),
    .ch_dat_tkeep(ch_dat_tkeep), .ch_dat_tlast(ch_dat_tlast),
    .ch_dat_tready(ch_dat_tready),
    .ins_hdr_tvalid(ins_hdr_tvalid), .ins_hdr_tdata(ins_hdr_tdata),
    .ins_hdr_tkeep(ins_hdr_tkeep), .ins_hdr_tready(ins_hdr_tready),
    .ins_dat_tvalid(ins_dat_tvalid), .ins_dat_tdata(ins_dat_tdata),
    .ins_dat_tkeep(ins_dat_tkeep), .ins_dat_tlast(ins_dat_tlast),
    .ins_dat_tready(ins_dat_tready),
    .ins_out_tvalid(ins_out_tvalid), .ins_out_tready(ins_out_tready),
    .ins_out_tlast(ins_out_tlast),
    .grant(grant), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hdr_hs = 0;

  // Running count of header handshakes on the requester side.
  always @(posedge clk)
    if (!rst) hdr_hs <= hdr_hs + $countones(ch_hdr_tvalid & ch_hdr_tready);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic hv, input logic [DW-1:0] hd, input logic [KW-1:0] hk,
                        input logic dv, input logic [DW-1:0] dd, input logic [KW-1:0] dk, input logic dl);
    ch_hdr_tvalid[i]        = hv;
    ch_hdr_tdata[i*DW +: DW] = hd;
    ch_hdr_tkeep[i*KW +: KW] = hk;
    ch_dat_tvalid[i]        = dv;
    ch_dat_tdata[i*DW +: DW] = dd;
    ch_dat_tkeep[i*KW +: KW] = dk;
    ch_dat_tlast[i]         = dl;
  endtask

  task automatic clr_ch();
    ch_hdr_tvalid = '0; ch_hdr_tdata = '0; ch_hdr_tkeep = '0;
    ch_dat_tvalid = '0; ch_dat_tdata = '0; ch_dat_tkeep = '0; ch_dat_tlast = '0;
  endtask

  task automatic set_out(input logic v, input logic r, input logic l);
    ins_out_tvalid = v; ins_out_tready = r; ins_out_tlast = l;
  endtask

  initial begin
    int h0;
    int beat;
    logic [DW-1:0] dv [3];
    dv[0] = 32'hB000_0010; dv[1] = 32'hB000_0011; dv[2] = 32'hB000_0012;

    clr_ch();
    ins_hdr_tready = 1'b0; ins_dat_tready = 1'b0;
    set_out(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); tick();

    // ---- reset state
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", pkt_cnt, 0);
    chk("rst_hrdy", ch_hdr_tready, 0);
    chk("rst_drdy", ch_dat_tready, 0);
    chk("rst_ihv", ins_hdr_tvalid, 0);
    chk("rst_idv", ins_dat_tvalid, 0);
    rst = 1'b0;

    // ---- single channel, 3-beat packet, no tail
    h0 = hdr_hs;
    set_ch(1, 1'b1, 32'hA1A1_0001, 4'b0011, 1'b1, 32'h1111_0000, 4'hF, 1'b0);
    ins_hdr_tready = 1'b1; ins_dat_tready = 1'b1;
    #1;
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_drdy", ch_dat_tready, 0);
    tick();
    chk("t1_grant", grant, 4'b0010);
    chk("t1_busy", busy, 1);
    chk("t1_hkeep", ins_hdr_tkeep, 4'b0011);
    chk("t1_hdata", ins_hdr_tdata, 32'hA1A1_0001);
    chk("t1_hrdy", ch_hdr_tready, 4'b0010);
    chk("t1_d0", ins_dat_tdata, 32'h1111_0000);
    tick();
    set_ch(1, 1'b1, 32'hA1A1_0001, 4'b0011, 1'b1, 32'h1111_0001, 4'hF, 1'b0);
    #1;
    chk("t1_hrdy_after", ch_hdr_tready, 0);
    chk("t1_ihv_after", ins_hdr_tvalid, 0);
    chk("t1_d1", ins_dat_tdata, 32'h1111_0001);
    tick();
    set_ch(1, 1'b1, 32'hA1A1_0001, 4'b0011, 1'b1, 32'h1111_0002, 4'hF, 1'b1);
    set_out(1'b1, 1'b1, 1'b1);
    #1;
    chk("t1_last", ins_dat_tlast, 1);
    tick();
    chk("t1_done_busy", busy, 0);
    chk("t1_done_grant", grant, 0);
    chk("t1_done_cnt", pkt_cnt, 1);
    chk("t1_one_hdr", hdr_hs - h0, 1);
    clr_ch();
    set_out(1'b0, 1'b0, 1'b0);

    // restart from ptr=0 for the round-robin check
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t2_rst_cnt", pkt_cnt, 0);

    // ---- all four channels request, 8 single-beat packets
    for (int i = 0; i < NCH; i++)
      set_ch(i, 1'b1, 32'hC000_0000 | i, 4'hF, 1'b1, 32'hD000_0000 | i, 4'hF, 1'b1);
    set_out(1'b1, 1'b1, 1'b1);
    for (int p = 0; p < 8; p++) begin
      #1;
      chk("t2_gap_grant", grant, 0);
      tick();
      chk("t2_grant", grant, 32'(1) << (p % NCH));
      chk("t2_data", ins_dat_tdata, 32'hD000_0000 | (p % NCH));
      tick();
      chk("t2_idle", busy, 0);
    end
    chk("t2_cnt", pkt_cnt, 8);
    clr_ch();
    set_out(1'b0, 1'b0, 1'b0);

    // ---- tail beat: one DRAIN cycle (ptr is back at 0)
    h0 = hdr_hs;
    set_ch(0, 1'b1, 32'hEE00_0000, 4'hF, 1'b1, 32'hEE00_0001, 4'hF, 1'b1);
    set_out(1'b1, 1'b1, 1'b0);
    tick();
    chk("t3_grant", grant, 4'b0001);
    tick();
    chk("t3_drain_busy", busy, 1);
    chk("t3_drain_grant", grant, 4'b0001);
    chk("t3_drain_ihv", ins_hdr_tvalid, 0);
    chk("t3_drain_idv", ins_dat_tvalid, 0);
    chk("t3_drain_hrdy", ch_hdr_tready, 0);
    chk("t3_drain_drdy", ch_dat_tready, 0);
    set_out(1'b1, 1'b1, 1'b1);
    tick();
    chk("t3_busy", busy, 0);
    chk("t3_cnt", pkt_cnt, 9);
    chk("t3_one_hdr", hdr_hs - h0, 1);
    clr_ch();
    set_out(1'b0, 1'b0, 1'b0);

    // ---- backpressure on ch1 (ptr=1): data ready 1,0,1,0,1; out held off
    set_ch(1, 1'b1, 32'hF1F1_0000, 4'hF, 1'b1, dv[0], 4'hF, 1'b0);
    set_out(1'b1, 1'b0, 1'b1);
    tick();
    chk("t4_grant", grant, 4'b0010);
    beat = 0;
    for (int c = 0; c < 10 && beat < 3; c++) begin
      set_ch(1, 1'b1, 32'hF1F1_0000, 4'hF, 1'b1, dv[beat], 4'hF, beat == 2);
      ins_dat_tready = (c % 2 == 0);
      #1;
      if (ins_dat_tvalid && ins_dat_tready) begin
        chk("t4_beat", ins_dat_tdata, dv[beat]);
        beat++;
      end
      tick();
    end
    chk("t4_beats", beat, 3);
    set_ch(1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    ins_dat_tready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_hold_grant", grant, 4'b0010);
      chk("t4_hold_idv", ins_dat_tvalid, 0);
      tick();
    end
    set_out(1'b1, 1'b1, 1'b1);
    tick();
    chk("t4_grant_clr", grant, 0);
    chk("t4_cnt", pkt_cnt, 10);
    clr_ch();

    // ---- header-only requester ch2 vs full requester ch3 (ptr=2)
    set_ch(2, 1'b1, 32'h2222_0000, 4'hF, 1'b0, '0, '0, 1'b0);
    set_ch(3, 1'b1, 32'h3333_0000, 4'hF, 1'b1, 32'h3333_0001, 4'hF, 1'b1);
    tick();
    chk("t5_grant3", grant, 4'b1000);
    tick();
    chk("t5_cnt", pkt_cnt, 11);
    set_ch(3, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    tick();
    chk("t5_no_grant", grant, 0);
    chk("t5_no_busy", busy, 0);
    set_ch(2, 1'b1, 32'h2222_0000, 4'hF, 1'b1, 32'h2222_0001, 4'hF, 1'b0);
    set_out(1'b0, 1'b0, 1'b0);
    tick();
    chk("t5_grant2", grant, 4'b0100);

    // ---- reset in the middle of ch2's packet
    tick();
    rst = 1'b1;
    tick();
    chk("t6_grant", grant, 0);
    chk("t6_busy", busy, 0);
    chk("t6_hrdy", ch_hdr_tready, 0);
    chk("t6_drdy", ch_dat_tready, 0);
    chk("t6_cnt", pkt_cnt, 0);
    rst = 1'b0;
    set_ch(1, 1'b1, 32'h1, 4'hF, 1'b1, 32'h2, 4'hF, 1'b1);
    set_ch(3, 1'b1, 32'h3, 4'hF, 1'b1, 32'h4, 4'hF, 1'b1);
    tick();
    chk("t6_lowest", grant, 4'b0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #20000;
    $display("FAIL watchdog: sequence did not complete");
    $fatal(1);
  end

endmodule
